// File: rtl/clause_table_scanner_pkg.sv
// clause_table_scanner_pkg
//   Shared types and sizing for the clause table scanner.
//   CLAUSE_TABLE_BITS / MAX_CLAUSES_BITS are system-wide widths. They are
//   defined here only when the build has not already provided them.
//   Contents:
//     scan_state_t  - scanner FSM state encoding
//     scan_entry_t  - one skid FIFO word {clause, last}
//     SKID_DEPTH    - skid FIFO depth (only 2 is supported)

`ifndef CLAUSE_TABLE_BITS
`define CLAUSE_TABLE_BITS 6
`endif

`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 10
`endif

package clause_table_scanner_pkg;

    localparam int TBL_W      = `CLAUSE_TABLE_BITS;
    localparam int CL_W       = `MAX_CLAUSES_BITS;
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        ERROR = 2'd3
    } scan_state_t;

    typedef struct packed {
        logic [CL_W-1:0] clause;
        logic            last;
    } scan_entry_t;

endpackage

// File: rtl/scan_skid_fifo.sv
// scan_skid_fifo
//   Two-entry FIFO that absorbs the one-cycle table read latency while the
//   clause evaluator back-pressures. Push and pop in the same cycle are both
//   honoured, including when the FIFO is full. Flush empties it and drops any
//   push of that cycle.
//   Ports:
//     clock, reset      - clock, asynchronous active-low reset
//     push, push_data   - write one entry
//     pop               - remove head entry (ignored when empty)
//     flush             - discard all contents
//     head              - current head entry
//     empty, full, count - occupancy status

module scan_skid_fifo
    import clause_table_scanner_pkg::*;
#(
    parameter int DEPTH = SKID_DEPTH
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  scan_entry_t push_data,
    input  logic        pop,
    input  logic        flush,
    output scan_entry_t head,
    output logic        empty,
    output logic        full,
    output logic [1:0]  count
);

    localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

    scan_entry_t mem_q [2];
    scan_entry_t mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        // A full FIFO may still accept a push when its head leaves this cycle.
        do_push  = push && ((count_q != DEPTH_CNT) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = !wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = !rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == 2'd0);
    assign full  = (count_q == DEPTH_CNT);
    assign count = count_q;

endmodule

// File: rtl/clause_table_scanner.sv
// clause_table_scanner
//   Walks a contiguous range of clause_table entries and streams the returned
//   clause indices to the clause evaluator over valid/ready.
//   Ports:
//     clock, reset            - clock, asynchronous active-low reset
//     start, start_index,
//     count, abort            - scan control from the solver controller
//     busy, done, scan_error  - scan status to the solver controller
//     tbl_read, tbl_index     - read request to clause_table
//     tbl_clause, tbl_error   - clause_table response, one cycle after read
//     clause_valid/ready/out,
//     clause_last             - clause stream to the evaluator
//   CLAUSE_BITS must equal the package entry width (MAX_CLAUSES_BITS).
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; a zero-length start only pulses done
//   ISSUE | issuing reads while the skid FIFO has room for the response
//   DRAIN | all reads issued; waiting for the last-tagged word to leave
//   ERROR | table flagged an error; scan_error is high for this one cycle

module clause_table_scanner
    import clause_table_scanner_pkg::*;
#(
    parameter int TABLE_BITS  = `CLAUSE_TABLE_BITS,
    parameter int CLAUSE_BITS = `MAX_CLAUSES_BITS,
    parameter int BUF_DEPTH   = SKID_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [TABLE_BITS-1:0]  start_index,
    input  logic [TABLE_BITS:0]    count,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   scan_error,
    output logic                   tbl_read,
    output logic [TABLE_BITS-1:0]  tbl_index,
    input  logic [CLAUSE_BITS-1:0] tbl_clause,
    input  logic                   tbl_error,
    output logic                   clause_valid,
    input  logic                   clause_ready,
    output logic [CLAUSE_BITS-1:0] clause_out,
    output logic                   clause_last
);

    localparam logic [TABLE_BITS-1:0] IDX_ONE = TABLE_BITS'(1);
    localparam logic [TABLE_BITS:0]   REM_ONE = (TABLE_BITS + 1)'(1);

    scan_state_t           state_q, state_d;
    logic [TABLE_BITS-1:0] next_idx_q, next_idx_d;
    logic [TABLE_BITS:0]   remaining_q, remaining_d;
    logic                  in_flight_q, in_flight_d;
    logic                  last_in_flight_q, last_in_flight_d;
    logic                  done_zero_q, done_zero_d;

    scan_entry_t           fifo_head;
    scan_entry_t           push_entry;
    logic                  fifo_empty, fifo_full;
    logic                  fifo_push, fifo_pop, fifo_flush;
    logic [1:0]            fifo_count;

    logic                  scanning, resp_live, resp_err, last_pop;
    logic [2:0]            occ_sum;

    scan_skid_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_comb begin
        scanning  = (state_q == ISSUE) || (state_q == DRAIN);
        fifo_pop  = !fifo_empty && clause_ready;
        // Responses that land after an abort or error are stale and dropped.
        resp_live = in_flight_q && scanning;
        resp_err  = resp_live && tbl_error;
        last_pop  = (state_q == DRAIN) && fifo_pop && fifo_head.last && !abort;

        // Issue only if the response will find a free slot: occupancy after
        // this cycle's pop plus the word already in flight must stay below 2.
        // Counting the pop keeps one clause per cycle under ready=1.
        occ_sum  = {1'b0, fifo_count} + {2'b00, in_flight_q};
        tbl_read = (state_q == ISSUE) && !abort && !resp_err
                   && (remaining_q != '0)
                   && (occ_sum < (3'd2 + {2'b00, fifo_pop}));

        fifo_flush        = (abort && (state_q != IDLE)) || resp_err;
        fifo_push         = resp_live && !tbl_error && (!fifo_full || fifo_pop);
        push_entry.clause = tbl_clause;
        push_entry.last   = last_in_flight_q;

        state_d          = state_q;
        next_idx_d       = next_idx_q;
        remaining_d      = remaining_q;
        in_flight_d      = tbl_read;
        last_in_flight_d = tbl_read && (remaining_q == REM_ONE);
        done_zero_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (count != '0) begin
                        next_idx_d  = start_index;
                        remaining_d = count;
                        state_d     = ISSUE;
                    end else begin
                        done_zero_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (resp_err) begin
                    state_d = ERROR;
                end else if (tbl_read) begin
                    next_idx_d  = next_idx_q + IDX_ONE;
                    remaining_d = remaining_q - REM_ONE;
                    if (remaining_q == REM_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (resp_err) begin
                    state_d = ERROR;
                end else if (last_pop) begin
                    state_d = IDLE;
                end
            end
            ERROR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            next_idx_q       <= '0;
            remaining_q      <= '0;
            in_flight_q      <= 1'b0;
            last_in_flight_q <= 1'b0;
            done_zero_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            next_idx_q       <= next_idx_d;
            remaining_q      <= remaining_d;
            in_flight_q      <= in_flight_d;
            last_in_flight_q <= last_in_flight_d;
            done_zero_q      <= done_zero_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign scan_error   = (state_q == ERROR);
    assign done         = done_zero_q || last_pop;
    assign tbl_index    = next_idx_q;
    assign clause_valid = !fifo_empty;
    // Gate the head so an empty FIFO always presents zeros downstream.
    assign clause_out   = fifo_empty ? '0 : fifo_head.clause;
    assign clause_last  = !fifo_empty && fifo_head.last;

endmodule

// File: tb/tb_clause_table_scanner.sv
// Directed testbench for clause_table_scanner with a behavioural clause_table
// holding 25 entries; reads at index >= 25 return tbl_error.

module tb_clause_table_scanner;

    localparam int TB = 6;
    localparam int CB = 10;
    localparam int NUM_ENTRIES = 25;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [TB-1:0] start_index = '0;
    logic [TB:0]   count = '0;
    logic          abort = 1'b0;
    logic          busy, done, scan_error, tbl_read;
    logic [TB-1:0] tbl_index;
    logic [CB-1:0] tbl_clause = '0;
    logic          tbl_error = 1'b0;
    logic          clause_valid;
    logic          clause_ready = 1'b0;
    logic [CB-1:0] clause_out;
    logic          clause_last;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [CB-1:0] tbl_mem [NUM_ENTRIES];

    // Results of the most recent run_collect.
    logic [CB-1:0] got_clause [$];
    logic          got_last [$];
    int            got_cyc [$];
    int done_cnt, err_cnt, rd_cnt, busy_cnt, done_on_last;
    int done_cyc, err_cyc;
    logic busy_first, valid_at_err, busy_at_err, busy_after_err;

    clause_table_scanner #(
        .TABLE_BITS  (TB),
        .CLAUSE_BITS (CB),
        .BUF_DEPTH   (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .start_index  (start_index),
        .count        (count),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .scan_error   (scan_error),
        .tbl_read     (tbl_read),
        .tbl_index    (tbl_index),
        .tbl_clause   (tbl_clause),
        .tbl_error    (tbl_error),
        .clause_valid (clause_valid),
        .clause_ready (clause_ready),
        .clause_out   (clause_out),
        .clause_last  (clause_last)
    );

    always #5 clock = ~clock;

    // clause_table model: one-cycle read latency, garbage when not read.
    always @(posedge clock) begin
        if (tbl_read) begin
            if (int'(tbl_index) < NUM_ENTRIES) begin
                tbl_clause <= tbl_mem[tbl_index];
                tbl_error  <= 1'b0;
            end else begin
                tbl_clause <= 10'h3ff;
                tbl_error  <= 1'b1;
            end
        end else begin
            tbl_clause <= 10'h155;
            tbl_error  <= 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "timeout");
    end

    // Drive a start pulse for exactly one rising edge; call from a negedge.
    task automatic start_scan(input logic [TB-1:0] idx, input logic [TB:0] cnt);
        start       = 1'b1;
        start_index = idx;
        count       = cnt;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Sample the DUT for ncyc cycles (at negedge+1) with inputs held.
    task automatic run_collect(input int ncyc);
        got_clause.delete();
        got_last.delete();
        got_cyc.delete();
        done_cnt = 0; err_cnt = 0; rd_cnt = 0; busy_cnt = 0; done_on_last = 0;
        done_cyc = -1; err_cyc = -1;
        busy_first = 1'b0; valid_at_err = 1'b1; busy_at_err = 1'b0; busy_after_err = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clock);
            #1;
            if (c == 0) busy_first = busy;
            if (clause_valid && clause_ready) begin
                got_clause.push_back(clause_out);
                got_last.push_back(clause_last);
                got_cyc.push_back(c);
                if (clause_last && done) done_on_last++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (scan_error) begin
                err_cnt++;
                if (err_cyc < 0) begin
                    err_cyc      = c;
                    valid_at_err = clause_valid;
                    busy_at_err  = busy;
                end
            end
            if (err_cyc >= 0 && c == err_cyc + 1) busy_after_err = busy;
            if (tbl_read) rd_cnt++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset;
        #1;
        total_cnt++;
        if ({busy, done, scan_error, tbl_read, clause_valid, clause_last} !== 6'b0)
            $display("FAIL reset_flags got %b want 000000",
                     {busy, done, scan_error, tbl_read, clause_valid, clause_last});
        else pass_cnt++;
        total_cnt++;
        if (tbl_index !== '0) $display("FAIL reset_tbl_index got %0d want 0", tbl_index);
        else pass_cnt++;
        total_cnt++;
        if (clause_out !== '0) $display("FAIL reset_clause_out got %0d want 0", clause_out);
        else pass_cnt++;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        total_cnt++;
        if (busy !== 1'b0 || clause_valid !== 1'b0)
            $display("FAIL post_reset_idle got busy=%b valid=%b want 0 0", busy, clause_valid);
        else pass_cnt++;
    endtask

    task automatic test_full_scan;
        int nlast;
        @(negedge clock);
        clause_ready = 1'b1;
        start_scan(6'd0, 7'd25);
        run_collect(35);
        total_cnt++;
        if (busy_first !== 1'b1) $display("FAIL full_busy got %b want 1", busy_first);
        else pass_cnt++;
        total_cnt++;
        if (got_clause.size() != 25) $display("FAIL full_count got %0d want 25", got_clause.size());
        else pass_cnt++;
        for (int i = 0; i < got_clause.size() && i < 25; i++) begin
            total_cnt++;
            if (got_clause[i] !== tbl_mem[i])
                $display("FAIL full_data[%0d] got %0d want %0d", i, got_clause[i], tbl_mem[i]);
            else pass_cnt++;
        end
        nlast = 0;
        foreach (got_last[i]) if (got_last[i]) nlast++;
        total_cnt++;
        if (nlast != 1 || got_last.size() != 25 || got_last[got_last.size()-1] !== 1'b1)
            $display("FAIL full_last got %0d tags want 1 on entry 24", nlast);
        else pass_cnt++;
        total_cnt++;
        if (got_cyc.size() != 25 || got_cyc[24] - got_cyc[0] != 24)
            $display("FAIL full_back_to_back got %0d entries want 25 on consecutive cycles",
                     got_cyc.size());
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1 || done_on_last != 1)
            $display("FAIL full_done got %0d pulses (%0d on last) want 1 (1)", done_cnt, done_on_last);
        else pass_cnt++;
        total_cnt++;
        if (rd_cnt != 25 || err_cnt != 0)
            $display("FAIL full_reads got rd=%0d err=%0d want 25 0", rd_cnt, err_cnt);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL full_busy_end got %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_error_scan;
        int nlast;
        @(negedge clock);
        clause_ready = 1'b1;
        start_scan(6'd20, 7'd10);
        run_collect(20);
        total_cnt++;
        if (got_clause.size() != 5) $display("FAIL err_count got %0d want 5", got_clause.size());
        else pass_cnt++;
        for (int i = 0; i < got_clause.size() && i < 5; i++) begin
            total_cnt++;
            if (got_clause[i] !== tbl_mem[20+i])
                $display("FAIL err_data[%0d] got %0d want %0d", i, got_clause[i], tbl_mem[20+i]);
            else pass_cnt++;
        end
        nlast = 0;
        foreach (got_last[i]) if (got_last[i]) nlast++;
        total_cnt++;
        if (nlast != 0) $display("FAIL err_last got %0d tags want 0", nlast);
        else pass_cnt++;
        total_cnt++;
        if (err_cnt != 1 || done_cnt != 0)
            $display("FAIL err_pulses got err=%0d done=%0d want 1 0", err_cnt, done_cnt);
        else pass_cnt++;
        total_cnt++;
        if (valid_at_err !== 1'b0 || busy_at_err !== 1'b1)
            $display("FAIL err_flush got valid=%b busy=%b want 0 1", valid_at_err, busy_at_err);
        else pass_cnt++;
        total_cnt++;
        if (busy_after_err !== 1'b0) $display("FAIL err_busy_drop got %b want 0", busy_after_err);
        else pass_cnt++;
        total_cnt++;
        if (rd_cnt != 6) $display("FAIL err_reads got %0d want 6", rd_cnt);
        else pass_cnt++;
    endtask

    task automatic test_zero_count;
        @(negedge clock);
        clause_ready = 1'b1;
        start       = 1'b1;
        start_index = 6'd7;
        count       = '0;
        #1;
        total_cnt++;
        if (tbl_read !== 1'b0 || done !== 1'b0)
            $display("FAIL zero_start_cycle got rd=%b done=%b want 0 0", tbl_read, done);
        else pass_cnt++;
        @(posedge clock);
        #1;
        start = 1'b0;
        run_collect(5);
        total_cnt++;
        if (done_cnt != 1 || done_cyc != 0)
            $display("FAIL zero_done got %0d pulses at cycle %0d want 1 at 0", done_cnt, done_cyc);
        else pass_cnt++;
        total_cnt++;
        if (rd_cnt != 0 || busy_cnt != 0 || got_clause.size() != 0)
            $display("FAIL zero_quiet got rd=%0d busy=%0d words=%0d want 0 0 0",
                     rd_cnt, busy_cnt, got_clause.size());
        else pass_cnt++;
    endtask

    task automatic test_stall;
        int occ_m, inf_m, pop_i, throttle_bad, unstable, valid_bad, dn, nlast;
        logic          hold;
        logic [CB-1:0] prev_clause;
        logic          prev_last;
        logic [CB-1:0] words [$];
        logic          lasts [$];
        occ_m = 0; inf_m = 0; throttle_bad = 0; unstable = 0; valid_bad = 0; dn = 0;
        hold = 1'b0; prev_clause = '0; prev_last = 1'b0;
        @(negedge clock);
        clause_ready = 1'b0;
        start_scan(6'd3, 7'd5);
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            clause_ready = (c % 3 == 0);
            #1;
            pop_i = (clause_valid && clause_ready) ? 1 : 0;
            if (hold && (!clause_valid || clause_out !== prev_clause || clause_last !== prev_last))
                unstable++;
            if (clause_valid !== (occ_m != 0)) valid_bad++;
            if (tbl_read && (occ_m + inf_m - pop_i) >= 2) throttle_bad++;
            if (pop_i == 1) begin
                words.push_back(clause_out);
                lasts.push_back(clause_last);
            end
            if (done) dn++;
            hold        = clause_valid && !clause_ready;
            prev_clause = clause_out;
            prev_last   = clause_last;
            occ_m       = occ_m - pop_i + inf_m;
            inf_m       = tbl_read ? 1 : 0;
        end
        clause_ready = 1'b1;
        total_cnt++;
        if (words.size() != 5) $display("FAIL stall_count got %0d want 5", words.size());
        else pass_cnt++;
        for (int i = 0; i < words.size() && i < 5; i++) begin
            total_cnt++;
            if (words[i] !== tbl_mem[3+i])
                $display("FAIL stall_data[%0d] got %0d want %0d", i, words[i], tbl_mem[3+i]);
            else pass_cnt++;
        end
        nlast = 0;
        foreach (lasts[i]) if (lasts[i]) nlast++;
        total_cnt++;
        if (nlast != 1 || lasts.size() != 5 || lasts[lasts.size()-1] !== 1'b1)
            $display("FAIL stall_last got %0d tags want 1 on final entry", nlast);
        else pass_cnt++;
        total_cnt++;
        if (unstable != 0) $display("FAIL stall_stable got %0d changes want 0", unstable);
        else pass_cnt++;
        total_cnt++;
        if (throttle_bad != 0) $display("FAIL stall_throttle got %0d overreads want 0", throttle_bad);
        else pass_cnt++;
        total_cnt++;
        if (valid_bad != 0) $display("FAIL stall_valid got %0d mismatched cycles want 0", valid_bad);
        else pass_cnt++;
        total_cnt++;
        if (dn != 1) $display("FAIL stall_done got %0d pulses want 1", dn);
        else pass_cnt++;
    endtask

    task automatic test_abort;
        int pulses;
        // abort together with start in IDLE: start is dropped
        @(negedge clock);
        clause_ready = 1'b1;
        abort        = 1'b1;
        start_scan(6'd0, 7'd3);
        abort = 1'b0;
        run_collect(6);
        total_cnt++;
        if (rd_cnt != 0 || busy_cnt != 0 || done_cnt != 0)
            $display("FAIL abort_start_drop got rd=%0d busy=%0d done=%0d want 0 0 0",
                     rd_cnt, busy_cnt, done_cnt);
        else pass_cnt++;

        // abort three cycles into a long scan with the FIFO holding data
        @(negedge clock);
        clause_ready = 1'b0;
        start_scan(6'd0, 7'd25);
        pulses = 0;
        repeat (3) begin
            @(negedge clock);
            #1;
            if (done || scan_error) pulses++;
        end
        total_cnt++;
        if (clause_valid !== 1'b1 || busy !== 1'b1)
            $display("FAIL abort_pre got valid=%b busy=%b want 1 1", clause_valid, busy);
        else pass_cnt++;
        abort = 1'b1;
        #1;
        if (done || scan_error) pulses++;
        @(negedge clock);
        abort = 1'b0;
        #1;
        if (done || scan_error) pulses++;
        total_cnt++;
        if (clause_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_flush got valid=%b busy=%b want 0 0", clause_valid, busy);
        else pass_cnt++;
        total_cnt++;
        if (pulses != 0) $display("FAIL abort_pulses got %0d want 0", pulses);
        else pass_cnt++;

        // new scan right away; stale response must not leak in
        clause_ready = 1'b1;
        start_scan(6'd10, 7'd2);
        run_collect(8);
        total_cnt++;
        if (got_clause.size() != 2 || got_clause[0] !== tbl_mem[10] || got_clause[1] !== tbl_mem[11])
            $display("FAIL abort_restart_data got %0d words first=%0d want 2 first=%0d",
                     got_clause.size(), (got_clause.size() > 0) ? got_clause[0] : 10'h0, tbl_mem[10]);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1 || err_cnt != 0 || got_last.size() != 2 || got_last[0] !== 1'b0 ||
            got_last[1] !== 1'b1)
            $display("FAIL abort_restart_done got done=%0d err=%0d want 1 0 with last on 2nd",
                     done_cnt, err_cnt);
        else pass_cnt++;
    endtask

    task automatic test_async_reset;
        @(negedge clock);
        clause_ready = 1'b1;
        start_scan(6'd0, 7'd25);
        repeat (4) @(negedge clock);
        #1;
        total_cnt++;
        if (busy !== 1'b1 || clause_valid !== 1'b1)
            $display("FAIL areset_pre got busy=%b valid=%b want 1 1", busy, clause_valid);
        else pass_cnt++;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, scan_error, tbl_read, clause_valid, clause_last} !== 6'b0)
            $display("FAIL areset_flags got %b want 000000",
                     {busy, done, scan_error, tbl_read, clause_valid, clause_last});
        else pass_cnt++;
        total_cnt++;
        if (tbl_index !== '0 || clause_out !== '0)
            $display("FAIL areset_data got idx=%0d out=%0d want 0 0", tbl_index, clause_out);
        else pass_cnt++;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        start_scan(6'd5, 7'd2);
        run_collect(8);
        total_cnt++;
        if (got_clause.size() != 2 || got_clause[0] !== tbl_mem[5] || got_clause[1] !== tbl_mem[6])
            $display("FAIL areset_rescan got %0d words first=%0d want 2 first=%0d",
                     got_clause.size(), (got_clause.size() > 0) ? got_clause[0] : 10'h0, tbl_mem[5]);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1 || got_last.size() != 2 || got_last[1] !== 1'b1)
            $display("FAIL areset_done got done=%0d want 1 with last on 2nd", done_cnt);
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            tbl_mem[i] = 10'((i * 97 + 13) % 1024);
        end
        #2;
        reset = 1'b0;
        test_reset();
        test_full_scan();
        test_error_scan();
        test_zero_count();
        test_stall();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
